// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl
//   Configuration controller and commit sequencer for a bank of sky130 GPIOv2
//   pad wrappers. Each pad has a shadow config (written from the register bus)
//   and an active config (driving the pad pins). A commit freezes all output
//   drivers, copies shadow to active for every pad at once, and keeps the
//   drivers frozen while the new pad settings settle.
//
//   Config word layout (9 bits):
//     {oe_en, hld_ovr, ib_mode_sel, vtrip_sel, slow, inp_dis, dm[2:0]}
//
//   Ports
//     clk, rst          single clock, synchronous active-high reset
//     cfg_valid/ready   config write handshake (ready only while idle)
//     cfg_pad/cfg_data  target pad index and config word
//     cfg_err           one-cycle pulse after a write to a non-existent pad
//     commit            pulse: apply all shadow configs (ignored when busy)
//     busy              sequencer is not idle
//     core_out/core_oe  core-side output data / enable per pad
//     core_in           pad input to core, gated by inp_dis
//     pad_*             pad-side pins (OUT, OE_N, DM, INP_DIS, SLOW,
//                       VTRIP_SEL, IB_MODE_SEL, HLD_OVR, IN)
//
//   Build option
//     GPIO_PAD_CTRL_INSYNC_EN  when defined, pad_in passes through a 2-flop
//                              synchronizer before the inp_dis gating.

module gpio_pad_ctrl #(
  parameter int NUM_PADS      = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int PAD_IDX_W     = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [PAD_IDX_W-1:0]    cfg_pad,
  input  logic [8:0]              cfg_data,
  output logic                    cfg_err,
  input  logic                    commit,
  output logic                    busy,
  input  logic [NUM_PADS-1:0]     core_out,
  input  logic [NUM_PADS-1:0]     core_oe,
  output logic [NUM_PADS-1:0]     core_in,
  output logic [NUM_PADS-1:0]     pad_out,
  output logic [NUM_PADS-1:0]     pad_oe_n,
  output logic [3*NUM_PADS-1:0]   pad_dm,
  output logic [NUM_PADS-1:0]     pad_inp_dis,
  output logic [NUM_PADS-1:0]     pad_slow,
  output logic [NUM_PADS-1:0]     pad_vtrip_sel,
  output logic [NUM_PADS-1:0]     pad_ib_mode_sel,
  output logic [NUM_PADS-1:0]     pad_hld_ovr,
  input  logic [NUM_PADS-1:0]     pad_in
);

  localparam int              CNT_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  // Safe power-up config: weak pull (dm=001), input buffer disabled, driver off.
  localparam logic [8:0]      RESET_CFG = 9'h009;

  typedef enum logic [1:0] {IDLE, FREEZE, APPLY, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cfg_err_q, cfg_err_d;
  logic [8:0]       shadow_q [NUM_PADS];
  logic [8:0]       shadow_d [NUM_PADS];
  logic [8:0]       active_q [NUM_PADS];
  logic [8:0]       active_d [NUM_PADS];

  logic             cfg_accept;
  logic             pad_ok;
  logic [NUM_PADS-1:0] pad_in_s;

  assign cfg_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign cfg_err    = cfg_err_q;
  assign cfg_accept = cfg_valid & cfg_ready;
  // Extra bit so an index equal to NUM_PADS compares correctly.
  assign pad_ok     = ({1'b0, cfg_pad} < (PAD_IDX_W + 1)'(NUM_PADS));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cfg_err_d = 1'b0;
    shadow_d  = shadow_q;
    active_d  = active_q;

    // Writes only reach shadow; a write in the same cycle as commit lands
    // before APPLY reads shadow, so that commit picks it up.
    if (cfg_accept) begin
      if (pad_ok) begin
        for (int i = 0; i < NUM_PADS; i++) begin
          if (cfg_pad == PAD_IDX_W'(i)) shadow_d[i] = cfg_data;
        end
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (commit) begin
          state_d = FREEZE;
          cnt_d   = '0;
        end
      end
      FREEZE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = APPLY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      APPLY: begin
        active_d = shadow_q;
        state_d  = RELEASE;
        cnt_d    = '0;
      end
      RELEASE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
      for (int i = 0; i < NUM_PADS; i++) begin
        shadow_q[i] <= RESET_CFG;
        active_q[i] <= RESET_CFG;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_err_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
    end
  end

`ifdef GPIO_PAD_CTRL_INSYNC_EN
  logic [NUM_PADS-1:0] sync1_q, sync1_d;
  logic [NUM_PADS-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = pad_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign pad_in_s = sync2_q;
`else
  assign pad_in_s = pad_in;
`endif

  assign pad_out = core_out;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PADS; gi++) begin : g_pad
      // Any non-idle state forces every driver off.
      assign pad_oe_n[gi]        = ~(core_oe[gi] & active_q[gi][8]) | busy;
      assign pad_hld_ovr[gi]     = active_q[gi][7];
      assign pad_ib_mode_sel[gi] = active_q[gi][6];
      assign pad_vtrip_sel[gi]   = active_q[gi][5];
      assign pad_slow[gi]        = active_q[gi][4];
      assign pad_inp_dis[gi]     = active_q[gi][3];
      assign pad_dm[3*gi +: 3]   = active_q[gi][2:0];
      assign core_in[gi]         = pad_in_s[gi] & ~active_q[gi][3];
    end
  endgenerate

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
module tb_gpio_pad_ctrl;

  localparam int NP = 6;   // leaves indices 6,7 unused so bad-index writes are possible
  localparam int S  = 4;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [IW-1:0]   cfg_pad;
  logic [8:0]      cfg_data;
  logic            cfg_err;
  logic            commit;
  logic            busy;
  logic [NP-1:0]   core_out, core_oe, core_in;
  logic [NP-1:0]   pad_out, pad_oe_n, pad_inp_dis, pad_slow, pad_vtrip_sel;
  logic [NP-1:0]   pad_ib_mode_sel, pad_hld_ovr, pad_in;
  logic [3*NP-1:0] pad_dm;

  int n_checks = 0;
  int n_errors = 0;

  gpio_pad_ctrl #(.NUM_PADS(NP), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pad(cfg_pad),
    .cfg_data(cfg_data), .cfg_err(cfg_err), .commit(commit), .busy(busy),
    .core_out(core_out), .core_oe(core_oe), .core_in(core_in),
    .pad_out(pad_out), .pad_oe_n(pad_oe_n), .pad_dm(pad_dm),
    .pad_inp_dis(pad_inp_dis), .pad_slow(pad_slow), .pad_vtrip_sel(pad_vtrip_sel),
    .pad_ib_mode_sel(pad_ib_mode_sel), .pad_hld_ovr(pad_hld_ovr), .pad_in(pad_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Counts clock edges until busy drops; an expired bound counts as a failure.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    if (busy) check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic write_cfg(input logic [IW-1:0] pad, input logic [8:0] data);
    cfg_valid = 1'b1;
    cfg_pad   = pad;
    cfg_data  = data;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_commit;
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first_dm, busy_cnt;
    rst = 1'b1; cfg_valid = 1'b0; cfg_pad = '0; cfg_data = '0; commit = 1'b0;
    core_out = 6'h25; core_oe = 6'h3F; pad_in = 6'h3F;
    step(); step();
    rst = 1'b0;
    #1;

    // 1. Reset state
    check("rst_oe_n",    32'(pad_oe_n),    32'h3F);
    check("rst_dm",      32'(pad_dm),      32'h09249);
    check("rst_inp_dis", 32'(pad_inp_dis), 32'h3F);
    check("rst_core_in", 32'(core_in),     32'h00);
    check("rst_ready",   32'(cfg_ready),   32'd1);
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_err",     32'(cfg_err),     32'd0);
    check("pad_out",     32'(pad_out),     32'h25);

    // 2. Write pad 2 then commit
    write_cfg(3'd2, 9'h106);
    check("write_no_pin_change", 32'(pad_dm), 32'h09249);
    pulse_commit();
    first_dm = -1; busy_cnt = 0; n = 0;
    while (busy && n < 40) begin
      busy_cnt++;
      if (pad_oe_n != 6'h3F) check("frozen_oe_n", 32'(pad_oe_n), 32'h3F);
      if (first_dm < 0 && pad_dm[8:6] == 3'b110) first_dm = n;
      step();
      n++;
    end
    check("busy_samples",     32'(busy_cnt), 32'(2*S + 1));
    check("commit_to_idle",   32'(n + 1),    32'(2*S + 2));
    check("dm_change_sample", 32'(first_dm), 32'(S + 1));
    check("t2_dm",      32'(pad_dm),      32'h09389);
    check("t2_oe_n",    32'(pad_oe_n),    32'h3B);
    check("t2_inp_dis", 32'(pad_inp_dis), 32'h3B);
    check("t2_core_in", 32'(core_in),     32'h04);
    core_oe = 6'h3B; #1;
    check("t2_oe_follow_core", 32'(pad_oe_n), 32'h3F);
    core_oe = 6'h3F; #1;

    // 3. Bad index write
    write_cfg(3'd6, 9'h1FF);
    check("bad_err_pulse", 32'(cfg_err), 32'd1);
    step();
    check("bad_err_clear", 32'(cfg_err), 32'd0);
    pulse_commit();
    wait_idle(n);
    check("t3_dm",   32'(pad_dm),      32'h09389);
    check("t3_oe_n", 32'(pad_oe_n),    32'h3B);
    check("t3_slow", 32'(pad_slow),    32'h00);
    check("t3_hld",  32'(pad_hld_ovr), 32'h00);

    // 4. Write + commit same cycle, extra commit during FREEZE
    cfg_valid = 1'b1; cfg_pad = 3'd0; cfg_data = 9'h10E; commit = 1'b1;
    step();
    cfg_valid = 1'b0; commit = 1'b0;
    step();
    check("t4_ready_low", 32'(cfg_ready), 32'd0);
    commit = 1'b1;
    step();
    commit = 1'b0;
    wait_idle(n);
    check("t4_commit_to_idle", 32'(n + 3), 32'(2*S + 2));
    check("t4_dm",      32'(pad_dm),      32'h0938E);
    check("t4_oe_n",    32'(pad_oe_n),    32'h3A);
    check("t4_inp_dis", 32'(pad_inp_dis), 32'h3B);

    // 5. Reset during RELEASE
    write_cfg(3'd4, 9'h1FF);
    pulse_commit();
    for (int k = 0; k < S + 1; k++) step();
    check("t5_applied_hld", 32'(pad_hld_ovr), 32'h10);
    check("t5_in_release",  32'(busy),        32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("t5_busy",    32'(busy),        32'd0);
    check("t5_ready",   32'(cfg_ready),   32'd1);
    check("t5_oe_n",    32'(pad_oe_n),    32'h3F);
    check("t5_dm",      32'(pad_dm),      32'h09249);
    check("t5_inp_dis", 32'(pad_inp_dis), 32'h3F);
    check("t5_hld",     32'(pad_hld_ovr), 32'h00);
    check("t5_core_in", 32'(core_in),     32'h00);
    pulse_commit();
    wait_idle(n);
    check("t5_shadow_reset_dm", 32'(pad_dm), 32'h09249);

    // 6. Input path latency on pad 3
    write_cfg(3'd3, 9'h000);
    pulse_commit();
    wait_idle(n);
    pad_in = 6'h00;
    step(); step(); step();
    check("t6_core_in_low", 32'(core_in), 32'h00);
    pad_in = 6'h08;
    #1;
`ifdef GPIO_PAD_CTRL_INSYNC_EN
    check("t6_lag0", 32'(core_in), 32'h00);
    step();
    check("t6_lag1", 32'(core_in), 32'h00);
    step();
    check("t6_lag2", 32'(core_in), 32'h08);
`else
    check("t6_comb", 32'(core_in), 32'h08);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
